// File: rtl/uart_tx_param.sv
// ---------------------------------------------------------------------------
// uart_tx_param
// Parametrised UART transmitter with a one-entry holding register.
//
// A byte offered on `data` with `send_en` is taken into the holding register
// whenever `tx_ready` is high. The holding register feeds the shifter as soon
// as the line is free, so queued bytes go out back-to-back with no idle gap.
// Baud, parity and stop-bit selection are latched at the start of each frame,
// so changing them mid-frame only affects the next frame.
//
// Parameters
//   CLK_FREQ     system clock frequency in Hz
//   DATA_W       data bits per frame (5..9)
//
// Ports
//   clk          system clock, all logic on the rising edge
//   reset        synchronous, active-high reset
//   data         byte to send, sampled on the accepting edge
//   send_en      request; accepted on an edge where send_en && tx_ready
//   tx_ready     holding register empty
//   baud_set     baud select (0:9600 .. 7:921600, 8..15:9600)
//   parity_mode  0/3 none, 1 odd, 2 even
//   stop2        0 one stop bit, 1 two stop bits
//   uart_tx      serial line, idle high, registered
//   busy         a frame is being shifted
//   tx_done      one-clock pulse on the last clock of the final stop bit
// ---------------------------------------------------------------------------
module uart_tx_param #(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned DATA_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data,
    input  logic              send_en,
    output logic              tx_ready,
    input  logic [3:0]        baud_set,
    input  logic [1:0]        parity_mode,
    input  logic              stop2,
    output logic              uart_tx,
    output logic              busy,
    output logic              tx_done
);

    function automatic int unsigned baud_rate(input int unsigned sel);
        case (sel)
            1:       return 19200;
            2:       return 38400;
            3:       return 57600;
            4:       return 115200;
            5:       return 230400;
            6:       return 460800;
            7:       return 921600;
            default: return 9600;
        endcase
    endfunction

    // Rounded clocks per bit, evaluated at elaboration only.
    function automatic int unsigned bit_period(input int unsigned sel);
        return (CLK_FREQ + baud_rate(sel) / 2) / baud_rate(sel);
    endfunction

    // 9600 baud is the slowest rate, so it sizes the bit counter.
    localparam int unsigned BP_MAX = bit_period(0);
    localparam int unsigned CNT_W  = (BP_MAX > 1) ? $clog2(BP_MAX) : 1;

    // Counter reload values (BP-1) for selects 0..7; 8..15 reuse entry 0.
    localparam logic [CNT_W-1:0] RELOAD [8] = '{
        CNT_W'(bit_period(0) - 1), CNT_W'(bit_period(1) - 1),
        CNT_W'(bit_period(2) - 1), CNT_W'(bit_period(3) - 1),
        CNT_W'(bit_period(4) - 1), CNT_W'(bit_period(5) - 1),
        CNT_W'(bit_period(6) - 1), CNT_W'(bit_period(7) - 1)
    };

    localparam logic [3:0] LAST_BIT = 4'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t            state, state_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic [3:0]        bit_idx, bit_idx_d;
    logic              stop_left, stop_left_d;   // another stop bit follows this one
    logic [DATA_W-1:0] shreg, shreg_d;
    logic              par_bit, par_bit_d;
    logic [CNT_W-1:0]  cfg_reload, cfg_reload_d;
    logic              cfg_par_en, cfg_par_en_d;
    logic              cfg_stop2, cfg_stop2_d;
    logic [DATA_W-1:0] hold_data;
    logic              hold_full, hold_full_d;
    logic              tx_q, tx_d;
    logic              take_hold;
    logic              accept;
    logic [CNT_W-1:0]  frame_reload;

    assign accept = send_en && !hold_full;

    always_comb begin
        frame_reload = RELOAD[0];
        if (!baud_set[3]) begin
            frame_reload = RELOAD[baud_set[2:0]];
        end
    end

    // NOTE: every variable gets a default at the top of the block, so no
    // path through the case statement can leave one unassigned (no latches).
    always_comb begin
        state_d      = state;
        cnt_d        = cnt;
        bit_idx_d    = bit_idx;
        stop_left_d  = stop_left;
        shreg_d      = shreg;
        par_bit_d    = par_bit;
        cfg_reload_d = cfg_reload;
        cfg_par_en_d = cfg_par_en;
        cfg_stop2_d  = cfg_stop2;
        take_hold    = 1'b0;

        case (state)
            S_IDLE: begin
                if (hold_full) begin
                    take_hold = 1'b1;
                end
            end
            S_START: begin
                if (cnt == '0) begin
                    state_d   = S_DATA;
                    cnt_d     = cfg_reload;
                    bit_idx_d = '0;
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end
            S_DATA: begin
                if (cnt == '0) begin
                    cnt_d = cfg_reload;
                    if (bit_idx == LAST_BIT) begin
                        stop_left_d = cfg_stop2;
                        state_d     = cfg_par_en ? S_PARITY : S_STOP;
                    end else begin
                        shreg_d   = shreg >> 1;
                        bit_idx_d = bit_idx + 4'd1;
                    end
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end
            S_PARITY: begin
                if (cnt == '0) begin
                    cnt_d       = cfg_reload;
                    stop_left_d = cfg_stop2;
                    state_d     = S_STOP;
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end
            S_STOP: begin
                if (cnt == '0) begin
                    if (stop_left) begin
                        stop_left_d = 1'b0;
                        cnt_d       = cfg_reload;
                    end else if (hold_full) begin
                        // Queued byte: next start bit follows with no idle gap.
                        take_hold = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Frame start: move the queued byte to the shifter and latch the
        // configuration that applies to the whole frame.
        if (take_hold) begin
            state_d      = S_START;
            cnt_d        = frame_reload;
            shreg_d      = hold_data;
            bit_idx_d    = '0;
            par_bit_d    = (^hold_data) ^ (parity_mode == 2'd1);
            cfg_reload_d = frame_reload;
            cfg_par_en_d = (parity_mode == 2'd1) || (parity_mode == 2'd2);
            cfg_stop2_d  = stop2;
        end

        hold_full_d = hold_full;
        if (take_hold) begin
            hold_full_d = 1'b0;
        end
        if (accept) begin
            hold_full_d = 1'b1;
        end

        // Line level follows the state being entered, so uart_tx is a flop.
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shreg_d[0];
            S_PARITY: tx_d = par_bit_d;
            default:  tx_d = 1'b1;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the values from before the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            hold_full <= 1'b0;
            tx_q      <= 1'b1;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            hold_full <= hold_full_d;
            tx_q      <= tx_d;
        end
    end

    // NOTE: datapath registers carry no reset; each is written before it is
    // used in a frame, and the control flops above gate their meaning.
    always_ff @(posedge clk) begin
        bit_idx    <= bit_idx_d;
        stop_left  <= stop_left_d;
        shreg      <= shreg_d;
        par_bit    <= par_bit_d;
        cfg_reload <= cfg_reload_d;
        cfg_par_en <= cfg_par_en_d;
        cfg_stop2  <= cfg_stop2_d;
        if (accept) begin
            hold_data <= data;
        end
    end

    assign tx_ready = !hold_full;
    assign uart_tx  = tx_q;
    assign busy     = (state != S_IDLE);
    assign tx_done  = (state == S_STOP) && (cnt == '0) && !stop_left;

endmodule
